// File: rtl/guess_pkg.sv
// Shared types and constants for the guess-entry block.
// Contents: FSM state enum, keypad command codes, slot storage type,
// blank-slot default and digit range.
package guess_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SLOTS      = 4;
  localparam int unsigned SLOT_IDX_W = 2;
  localparam int unsigned CNT_W      = 3;

  localparam logic [DIGIT_W-1:0] BLANK_DEFAULT = 4'hF;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX     = 4'd9;

  localparam logic [DIGIT_W-1:0] KEY_BKSP = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_CLR  = 4'hB;
  localparam logic [DIGIT_W-1:0] KEY_ENT  = 4'hC;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    SUBMIT  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Slot 0 holds the first digit entered.
  typedef logic [SLOTS-1:0][DIGIT_W-1:0] slots_t;

endpackage

// File: rtl/guess_dup_check.sv
// Combinational duplicate-digit detector.
// Ports: slots (four stored digits), count (number of valid slots),
//        digit (candidate), is_dup (candidate matches a valid slot).
module guess_dup_check
  import guess_pkg::*;
(
  input  slots_t             slots,
  input  logic [CNT_W-1:0]   count,
  input  logic [DIGIT_W-1:0] digit,
  output logic               is_dup
);

  // Only slots below count are compared, so blank slots never match.
  always_comb begin
    is_dup = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if ((CNT_W'(i) < count) && (slots[i] == digit)) begin
        is_dup = 1'b1;
      end
    end
  end

endmodule

// File: rtl/guess_entry.sv
// Guess-entry producer for one game round: assembles a 4-digit guess from
// keypad strobes, submits it to the evaluator, captures the result, counts
// attempts and declares win/lose.
// Ports: clk, rst (sync, active-high); key_valid/key_code keypad strobe;
//        new_game restart strobe; strike_in/ball_in/correct_in evaluator
//        result; reg_1..reg_4 guess digits; digit_count; submit pulse;
//        new_secret pulse; last_strike/last_ball; attempts; win/lose levels;
//        dup_err pulse.
module guess_entry
  import guess_pkg::*;
#(
  parameter int unsigned         MAX_ATTEMPTS = 10,
  parameter int unsigned         ATT_W        = 4,
  parameter logic [DIGIT_W-1:0]  BLANK        = BLANK_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               new_game,
  input  logic [2:0]         strike_in,
  input  logic [2:0]         ball_in,
  input  logic               correct_in,
  output logic [DIGIT_W-1:0] reg_1,
  output logic [DIGIT_W-1:0] reg_2,
  output logic [DIGIT_W-1:0] reg_3,
  output logic [DIGIT_W-1:0] reg_4,
  output logic [CNT_W-1:0]   digit_count,
  output logic               submit,
  output logic               new_secret,
  output logic [2:0]         last_strike,
  output logic [2:0]         last_ball,
  output logic [ATT_W-1:0]   attempts,
  output logic               win,
  output logic               lose,
  output logic               dup_err
);

  localparam slots_t           SLOTS_BLANK = {SLOTS{BLANK}};
  localparam logic [ATT_W-1:0] ATT_SAT     = '1;
  localparam logic [ATT_W-1:0] ATT_LIMIT   = ATT_W'(MAX_ATTEMPTS);

  state_t             state, state_n;
  slots_t             slots, slots_n;
  logic [CNT_W-1:0]   count_n;
  logic               submit_n, new_secret_n, dup_err_n, win_n, lose_n;
  logic [2:0]         last_strike_n, last_ball_n;
  logic [ATT_W-1:0]   attempts_n, att_inc;
  logic               is_dup;

  guess_dup_check u_dup (
    .slots  (slots),
    .count  (digit_count),
    .digit  (key_code),
    .is_dup (is_dup)
  );

  assign reg_1 = slots[0];
  assign reg_2 = slots[1];
  assign reg_3 = slots[2];
  assign reg_4 = slots[3];

  // Saturating attempt increment.
  assign att_inc = (attempts == ATT_SAT) ? attempts : attempts + ATT_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    slots_n       = slots;
    count_n       = digit_count;
    submit_n      = 1'b0;
    new_secret_n  = 1'b0;
    dup_err_n     = 1'b0;
    last_strike_n = last_strike;
    last_ball_n   = last_ball;
    attempts_n    = attempts;
    win_n         = win;
    lose_n        = lose;

    if (new_game) begin
      state_n       = ENTRY;
      slots_n       = SLOTS_BLANK;
      count_n       = '0;
      last_strike_n = '0;
      last_ball_n   = '0;
      attempts_n    = '0;
      win_n         = 1'b0;
      lose_n        = 1'b0;
      new_secret_n  = 1'b1;
    end else begin
      case (state)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= DIGIT_MAX) begin
              // A full guess silently ignores further digits.
              if (digit_count < CNT_W'(SLOTS)) begin
                if (is_dup) begin
                  dup_err_n = 1'b1;
                end else begin
                  slots_n[digit_count[SLOT_IDX_W-1:0]] = key_code;
                  count_n = digit_count + CNT_W'(1);
                end
              end
            end else begin
              case (key_code)
                KEY_BKSP: begin
                  if (digit_count != '0) begin
                    slots_n[SLOT_IDX_W'(digit_count - CNT_W'(1))] = BLANK;
                    count_n = digit_count - CNT_W'(1);
                  end
                end
                KEY_CLR: begin
                  slots_n = SLOTS_BLANK;
                  count_n = '0;
                end
                KEY_ENT: begin
                  if (digit_count == CNT_W'(SLOTS)) begin
                    state_n  = SUBMIT;
                    submit_n = 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        SUBMIT: state_n = CAPTURE;

        // Evaluator result was registered on the submit edge.
        CAPTURE: begin
          last_strike_n = strike_in;
          last_ball_n   = ball_in;
          attempts_n    = att_inc;
          if (correct_in) begin
            state_n = DONE;
            win_n   = 1'b1;
          end else if (att_inc == ATT_LIMIT) begin
            state_n = DONE;
            lose_n  = 1'b1;
          end else begin
            state_n = ENTRY;
            slots_n = SLOTS_BLANK;
            count_n = '0;
          end
        end

        DONE: ;

        default: state_n = ENTRY;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENTRY;
      slots       <= SLOTS_BLANK;
      digit_count <= '0;
      submit      <= 1'b0;
      new_secret  <= 1'b0;
      last_strike <= '0;
      last_ball   <= '0;
      attempts    <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      dup_err     <= 1'b0;
    end else begin
      state       <= state_n;
      slots       <= slots_n;
      digit_count <= count_n;
      submit      <= submit_n;
      new_secret  <= new_secret_n;
      last_strike <= last_strike_n;
      last_ball   <= last_ball_n;
      attempts    <= attempts_n;
      win         <= win_n;
      lose        <= lose_n;
      dup_err     <= dup_err_n;
    end
  end

endmodule

// File: tb/tb_guess_entry.sv
// Testbench for guess_entry: two instances (MAX_ATTEMPTS 10 and 2) share one
// stimulus stream; a list-based reference model predicts every output.
module tb_guess_entry;
  import guess_pkg::*;

  logic       clk = 1'b0;
  logic       rst, key_valid, new_game, correct_in;
  logic [3:0] key_code;
  logic [2:0] strike_in, ball_in;

  logic [3:0] ra1, ra2, ra3, ra4, rb1, rb2, rb3, rb4;
  logic [2:0] cnt_a, cnt_b, ls_a, ls_b, lb_a, lb_b;
  logic [3:0] att_a, att_b;
  logic       sub_a, sub_b, ns_a, ns_b, win_a, win_b, lose_a, lose_b, dup_a, dup_b;

  always #5 clk = ~clk;

  guess_entry dut_a (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .new_game(new_game), .strike_in(strike_in), .ball_in(ball_in),
    .correct_in(correct_in), .reg_1(ra1), .reg_2(ra2), .reg_3(ra3), .reg_4(ra4),
    .digit_count(cnt_a), .submit(sub_a), .new_secret(ns_a), .last_strike(ls_a),
    .last_ball(lb_a), .attempts(att_a), .win(win_a), .lose(lose_a), .dup_err(dup_a)
  );

  guess_entry #(.MAX_ATTEMPTS(2)) dut_b (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .new_game(new_game), .strike_in(strike_in), .ball_in(ball_in),
    .correct_in(correct_in), .reg_1(rb1), .reg_2(rb2), .reg_3(rb3), .reg_4(rb4),
    .digit_count(cnt_b), .submit(sub_b), .new_secret(ns_b), .last_strike(ls_b),
    .last_ball(lb_b), .attempts(att_b), .win(win_b), .lose(lose_b), .dup_err(dup_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: entered digits as a list, round progress as cycles since enter.
  int m_max [2];
  int m_dig [2][4];
  int m_n   [2];
  int m_age [2];
  bit m_done[2];
  int m_att [2];
  int m_ls  [2];
  int m_lb  [2];
  bit m_win [2];
  bit m_lose[2];
  bit m_sub [2];
  bit m_ns  [2];
  bit m_dup [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_clear(input int k);
    m_n[k] = 0;
    for (int i = 0; i < 4; i++) m_dig[k][i] = 15;
    m_age[k] = -1; m_done[k] = 0; m_att[k] = 0; m_ls[k] = 0; m_lb[k] = 0;
    m_win[k] = 0; m_lose[k] = 0; m_sub[k] = 0; m_ns[k] = 0; m_dup[k] = 0;
  endtask

  task automatic m_step(input int k);
    int kc;
    bit seen;
    kc = int'(key_code);
    m_sub[k] = 0; m_ns[k] = 0; m_dup[k] = 0;
    if (rst) m_clear(k);
    else if (new_game) begin
      m_clear(k);
      m_ns[k] = 1;
    end else if (m_done[k]) begin
    end else if (m_age[k] == 0) m_age[k] = 1;
    else if (m_age[k] == 1) begin
      m_ls[k] = int'(strike_in);
      m_lb[k] = int'(ball_in);
      if (m_att[k] < 15) m_att[k]++;
      if (correct_in) begin
        m_done[k] = 1; m_win[k] = 1;
      end else if (m_att[k] == m_max[k]) begin
        m_done[k] = 1; m_lose[k] = 1;
      end else begin
        m_n[k] = 0;
        for (int i = 0; i < 4; i++) m_dig[k][i] = 15;
        m_age[k] = -1;
      end
    end else if (key_valid) begin
      if (kc <= 9) begin
        if (m_n[k] < 4) begin
          seen = 0;
          for (int i = 0; i < m_n[k]; i++) if (m_dig[k][i] == kc) seen = 1;
          if (seen) m_dup[k] = 1;
          else begin
            m_dig[k][m_n[k]] = kc;
            m_n[k]++;
          end
        end
      end else if (kc == 10) begin
        if (m_n[k] > 0) begin
          m_n[k]--;
          m_dig[k][m_n[k]] = 15;
        end
      end else if (kc == 11) begin
        m_n[k] = 0;
        for (int i = 0; i < 4; i++) m_dig[k][i] = 15;
      end else if (kc == 12) begin
        if (m_n[k] == 4) begin
          m_age[k] = 0;
          m_sub[k] = 1;
        end
      end
    end
  endtask

  task automatic check_dut(input int k);
    string p;
    logic [3:0] o1, o2, o3, o4, oat;
    logic [2:0] ocn, ols, olb;
    logic osb, ons, owi, olo, odu;
    if (k == 0) begin
      p = "a"; o1 = ra1; o2 = ra2; o3 = ra3; o4 = ra4; ocn = cnt_a; osb = sub_a;
      ons = ns_a; ols = ls_a; olb = lb_a; oat = att_a; owi = win_a; olo = lose_a; odu = dup_a;
    end else begin
      p = "b"; o1 = rb1; o2 = rb2; o3 = rb3; o4 = rb4; ocn = cnt_b; osb = sub_b;
      ons = ns_b; ols = ls_b; olb = lb_b; oat = att_b; owi = win_b; olo = lose_b; odu = dup_b;
    end
    chk({p, ".reg_1"}, 32'(o1), m_dig[k][0]);
    chk({p, ".reg_2"}, 32'(o2), m_dig[k][1]);
    chk({p, ".reg_3"}, 32'(o3), m_dig[k][2]);
    chk({p, ".reg_4"}, 32'(o4), m_dig[k][3]);
    chk({p, ".digit_count"}, 32'(ocn), m_n[k]);
    chk({p, ".submit"}, 32'(osb), 32'(m_sub[k]));
    chk({p, ".new_secret"}, 32'(ons), 32'(m_ns[k]));
    chk({p, ".last_strike"}, 32'(ols), m_ls[k]);
    chk({p, ".last_ball"}, 32'(olb), m_lb[k]);
    chk({p, ".attempts"}, 32'(oat), m_att[k]);
    chk({p, ".win"}, 32'(owi), 32'(m_win[k]));
    chk({p, ".lose"}, 32'(olo), 32'(m_lose[k]));
    chk({p, ".dup_err"}, 32'(odu), 32'(m_dup[k]));
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic cyc(input bit r, input bit kv, input logic [3:0] kc, input bit ng,
                     input logic [2:0] st, input logic [2:0] bl, input bit cr);
    rst = r; key_valid = kv; key_code = kc; new_game = ng;
    strike_in = st; ball_in = bl; correct_in = cr;
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic key(input logic [3:0] kc);
    cyc(1'b0, 1'b1, kc, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic cap(input logic [2:0] st, input logic [2:0] bl, input bit cr);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, st, bl, cr);
  endtask

  initial begin
    bit r, kv, ng, cr;
    logic [3:0] kc;
    m_max[0] = 10;
    m_max[1] = 2;
    m_clear(0);
    m_clear(1);
    rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; new_game = 1'b0;
    strike_in = 3'd0; ball_in = 3'd0; correct_in = 1'b0;

    cyc(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("reset.attempts", 32'(att_a), 0);
    chk("reset.reg_1", 32'(ra1), 15);

    // First guess 1234, evaluator answers 1 strike 2 balls.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(KEY_ENT);
    chk("enter.submit", 32'(sub_a), 1);
    chk("enter.reg_4", 32'(ra4), 4);
    idle();
    chk("capture.submit", 32'(sub_a), 0);
    cap(3'd1, 3'd2, 1'b0);
    chk("g1.last_strike", 32'(ls_a), 1);
    chk("g1.last_ball", 32'(lb_a), 2);
    chk("g1.attempts", 32'(att_a), 1);
    chk("g1.count", 32'(cnt_a), 0);

    // Duplicate rejection and backspace at empty.
    key(4'd5); key(4'd5);
    chk("dup.err", 32'(dup_a), 1);
    chk("dup.count", 32'(cnt_a), 1);
    chk("dup.reg_2", 32'(ra2), 15);
    idle();
    chk("dup.pulse_end", 32'(dup_a), 0);
    key(KEY_BKSP); key(KEY_BKSP);
    chk("bksp.count", 32'(cnt_a), 0);
    chk("bksp.reg_1", 32'(ra1), 15);

    // Short enter ignored; digits beyond four ignored; 0xD ignored.
    key(4'd1); key(4'd2); key(4'd3); key(KEY_ENT);
    chk("short.submit", 32'(sub_a), 0);
    key(4'hD);
    key(4'd4); key(4'd7);
    chk("full.count", 32'(cnt_a), 4);
    chk("full.reg_4", 32'(ra4), 4);
    key(KEY_ENT); idle(); cap(3'd0, 3'd3, 1'b0);
    chk("g2.attempts_a", 32'(att_a), 2);
    chk("g2.lose_a", 32'(lose_a), 0);
    chk("g2.lose_b", 32'(lose_b), 1);
    chk("g2.win_b", 32'(win_b), 0);

    // Third guess wins on dut_a; keys afterwards ignored.
    key(4'd9); key(4'd8); key(4'd7); key(4'd6); key(KEY_ENT); idle();
    cap(3'd4, 3'd0, 1'b1);
    chk("g3.win", 32'(win_a), 1);
    chk("g3.lose", 32'(lose_a), 0);
    chk("g3.attempts", 32'(att_a), 3);
    key(KEY_CLR); key(4'd1);
    chk("done.count", 32'(cnt_a), 4);
    chk("done.reg_1", 32'(ra1), 9);
    cyc(1'b0, 1'b1, 4'd5, 1'b1, 3'd0, 3'd0, 1'b0);
    chk("newgame.secret", 32'(ns_a), 1);
    chk("newgame.win", 32'(win_a), 0);
    chk("newgame.count", 32'(cnt_a), 0);
    idle();
    chk("newgame.pulse_end", 32'(ns_a), 0);

    // Reset during the submit cycle.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(KEY_ENT);
    cyc(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk("rst_submit.submit", 32'(sub_a), 0);
    chk("rst_submit.count", 32'(cnt_a), 0);

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 399) == 0);
      ng = ($urandom_range(0, 39) == 0);
      kv = ($urandom_range(0, 9) < 6);
      kc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) kc = KEY_ENT;
      cr = ($urandom_range(0, 5) == 0);
      cyc(r, kv, kc, ng, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 4)), cr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_entry.md
Name: guess_entry

Overview:
- Producer side of the guess-evaluation interface: builds a 4-digit guess from keypad strobes and drives the four guess digits plus the one-cycle submit.
- Captures the registered STRIKE/BALL/correct result one cycle after submit, counts attempts, and declares win or lose.
- Sits between the keypad/button decoder and the guess evaluator; owns the whole guess-entry side of one game round.

Parameters:
- MAX_ATTEMPTS, 10: guesses allowed per game; must be between 1 and 2^ATT_W-1.
- ATT_W, 4: width of the attempt counter.
- BLANK, 4'hF: value driven on guess slots that have not been entered.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, active-high.
- key_valid  in  1  one-cycle strobe; key_code valid.
- key_code  in  4  0-9 digit; 0xA backspace; 0xB clear; 0xC enter; 0xD-0xF ignored.
- new_game  in  1  one-cycle strobe; restart game.
- strike_in  in  3  evaluator STRIKE, registered on the submit edge.
- ball_in  in  3  evaluator BALL.
- correct_in  in  1  evaluator correct.
- reg_1..reg_4  out  4 each  guess digits; reg_1 is the first digit entered.
- digit_count  out  3  digits currently entered, 0-4.
- submit  out  1  one-cycle guess-submit pulse.
- new_secret  out  1  one-cycle pulse to the secret generator enable.
- last_strike  out  3  captured strike of the last guess.
- last_ball  out  3  captured ball of the last guess.
- attempts  out  ATT_W  guesses evaluated this game.
- win  out  1  level; high in DONE after a correct guess.
- lose  out  1  level; high in DONE after attempts are exhausted.
- dup_err  out  1  one-cycle pulse; a duplicate digit was rejected.

Behaviour:
- Reset: rst is synchronous, active-high, on clk; it overrides everything.
  - Reset values: reg_1..4=BLANK; digit_count=0; submit=0; new_secret=0; last_strike=0; last_ball=0; attempts=0; win=0; lose=0; dup_err=0; state=ENTRY.
- new_game: next priority after rst, accepted in any state including mid-submit.
  - Next cycle: same values as reset, except new_secret=1 for exactly one cycle.
  - Any key in the same cycle is ignored.
- FSM states: ENTRY, SUBMIT, CAPTURE, DONE.
- ENTRY, on key_valid:
  - Digit 0-9, count<4, not equal to any entered slot: store at slot[count], count+1.
  - Digit equal to an entered slot: rejected; dup_err=1 next cycle.
  - Digit with count==4: ignored, no error.
  - Backspace with count>0: slot[count-1]=BLANK, count-1. With count==0: no-op.
  - Clear: all slots BLANK, count=0.
  - Enter with count==4: go to SUBMIT. With count<4: ignored.
  - Codes 0xD-0xF: ignored.
- SUBMIT: submit=1 for exactly this one cycle.
  - reg_1..4 stay stable from entry into SUBMIT until CAPTURE exits.
  - Keys ignored. Next state CAPTURE.
- CAPTURE: one cycle. The evaluator registered its result on the SUBMIT edge, so inputs are valid here.
  - Latch last_strike<=strike_in and last_ball<=ball_in.
  - attempts<=attempts+1, saturating at 2^ATT_W-1.
  - correct_in=1: go to DONE, win=1; guess digits retained.
  - Else attempts+1==MAX_ATTEMPTS: go to DONE, lose=1; guess digits retained.
  - Else: go to ENTRY with slots BLANK and count=0.
  - Keys ignored.
- DONE: all keys ignored; outputs hold; leave only via new_game or rst.
- win and lose are never both 1.
- Round latency: enter key cycle N; submit high at N+1; capture at N+2; outputs updated at N+3.
- Duplicate check compares only the valid slots (index < count); BLANK slots never match.

Decomposition:
- Package guess_pkg holds:
  - state enum (ENTRY, SUBMIT, CAPTURE, DONE);
  - key-code constants KEY_BKSP=4'hA, KEY_CLR=4'hB, KEY_ENT=4'hC;
  - BLANK default;
  - DIGIT_MAX=9.
- One sub-module, guess_dup_check: combinational, inputs four slots + count + candidate digit, output is_dup.
- FSM, slot registers and counters live in guess_entry.

Test Plan:
- Reset, then keys 1,2,3,4, enter -> reg_1..4=1,2,3,4; submit high exactly one cycle, 1 cycle after enter; no other submit.
- Keys 5,5 -> second 5 rejected; dup_err pulses one cycle; digit_count=1, reg_2=BLANK. Then bksp, bksp at count 0 -> count=0, all BLANK, no error.
- Keys 1,2,3, enter -> no submit. Then 4, 7 -> count stays 4, reg_4=4.
- Evaluator returns strike=1, ball=2, correct=0 -> one cycle after submit: last_strike=1, last_ball=2, attempts=1; state ENTRY, slots BLANK.
- correct_in=1 on attempt 3 -> win=1, lose=0, attempts=3. Later keys ignored. new_game -> all outputs back to reset values, new_secret pulses once.
- MAX_ATTEMPTS=2, two wrong guesses -> lose=1 after 2nd capture, attempts=2. rst asserted in SUBMIT cycle -> next cycle submit=0 and all reset values.
